// File: rtl/kronos_mem_pkg.sv
// Shared definitions for the Kronos memory adapter.
//   state_e        : adapter FSM states (IDLE, REQ, WAIT, RESP)
//   expand_mask()  : byte enables -> bit strobes (each mask bit replicated 8x)
//   MaxMemLatency  : upper bound of the MemLatency parameter
package kronos_mem_pkg;

    localparam int MaxMemLatency = 16;
    // Widest data bus the strobe helper supports; callers cast down to DataW.
    localparam int MaxDataW      = 256;
    localparam int MaxMaskW      = MaxDataW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic [MaxDataW-1:0] expand_mask(input logic [MaxMaskW-1:0] mask);
        logic [MaxDataW-1:0] strb;
        strb = '0;
        for (int i = 0; i < MaxMaskW; i++) begin
            strb[8*i +: 8] = {8{mask[i]}};
        end
        return strb;
    endfunction

endpackage

// File: rtl/kronos_mem_adapter.sv
// Bridge from a Kronos core memory port (req held until ack) to an SRAM-style
// port (req/gnt, fixed read latency MemLatency), with optional grant timeout.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   core_req_i/addr_i/wdata_i/mask_i/we_i  core request (sampled in IDLE only)
//   core_ack_o/rdata_o/err_o           one-cycle completion, data, timeout flag
//   mem_req_o/gnt_i                    memory handshake
//   mem_addr_o/wdata_o/strb_o/we_o     registered memory command
//   mem_rdata_i                        memory read data, valid MemLatency cycles after grant
//   busy_o                             transaction in progress
module kronos_mem_adapter
    import kronos_mem_pkg::*;
#(
    parameter int AddrW         = 20,
    parameter int DataW         = 32,
    parameter int MemLatency    = 1,
    parameter int TimeoutCycles = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_req_i,
    input  logic [31:0]        core_addr_i,
    input  logic [DataW-1:0]   core_wdata_i,
    input  logic [DataW/8-1:0] core_mask_i,
    input  logic               core_we_i,
    output logic               core_ack_o,
    output logic [DataW-1:0]   core_rdata_o,
    output logic               core_err_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [AddrW-1:0]   mem_addr_o,
    output logic [DataW-1:0]   mem_wdata_o,
    output logic [DataW-1:0]   mem_strb_o,
    output logic               mem_we_o,
    input  logic [DataW-1:0]   mem_rdata_i,
    output logic               busy_o
);

    localparam int LatW = $clog2(MaxMemLatency);
    localparam int ToW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [LatW-1:0] LatLoad = LatW'(MemLatency - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    state_e              state_r;
    logic [LatW-1:0]     lat_cnt_r;
    logic [ToW-1:0]      to_cnt_r;
    logic                err_r;
    logic                ack_r;
    logic                req_r;
    logic                busy_r;
    logic [DataW-1:0]    rdata_r;
    logic [AddrW-1:0]    addr_r;
    logic [DataW-1:0]    wdata_r;
    logic [DataW-1:0]    strb_r;
    logic                we_r;
    logic [MaxMaskW-1:0] mask_ext_s;

    // Widen the byte mask to the package helper's fixed argument width.
    always_comb begin
        mask_ext_s                = '0;
        mask_ext_s[DataW/8-1:0]   = core_mask_i;
    end

    // Adapter FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            lat_cnt_r <= '0;
            to_cnt_r  <= '0;
            err_r     <= 1'b0;
            ack_r     <= 1'b0;
            req_r     <= 1'b0;
            busy_r    <= 1'b0;
            rdata_r   <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            strb_r    <= '0;
            we_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (core_req_i) begin
                        addr_r   <= AddrW'(core_addr_i);
                        wdata_r  <= core_wdata_i;
                        strb_r   <= DataW'(expand_mask(mask_ext_s));
                        we_r     <= core_we_i;
                        to_cnt_r <= '0;
                        req_r    <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= REQ;
                    end
                end
                REQ: begin
                    // A grant in the timeout cycle takes priority over the error.
                    if (mem_gnt_i) begin
                        lat_cnt_r <= LatLoad;
                        req_r     <= 1'b0;
                        state_r   <= WAIT;
                    end else if (TimeoutCycles != 0) begin
                        if (to_cnt_r == ToLast) begin
                            err_r   <= 1'b1;
                            rdata_r <= '0;
                            req_r   <= 1'b0;
                            ack_r   <= 1'b1;
                            state_r <= RESP;
                        end else begin
                            to_cnt_r <= to_cnt_r + ToW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt_r == '0) begin
                        if (!we_r) begin
                            rdata_r <= mem_rdata_i;
                        end
                        err_r   <= 1'b0;
                        ack_r   <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LatW'(1);
                    end
                end
                RESP: begin
                    // err is only meaningful alongside ack, so drop it with ack.
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign core_ack_o   = ack_r;
    assign core_err_o   = err_r;
    assign core_rdata_o = rdata_r;
    assign mem_req_o    = req_r;
    assign mem_addr_o   = addr_r;
    assign mem_wdata_o  = wdata_r;
    assign mem_strb_o   = strb_r;
    assign mem_we_o     = we_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_kronos_mem_adapter.sv
// Self-checking bench: three adapters with different latency/timeout settings,
// a transaction-level schedule model, and a per-cycle compare process.
module tb_kronos_mem_adapter;

    localparam int MAXC = 512;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_mask;
    logic        core_we;
    logic        core_req  [0:2];
    logic        mem_gnt   [0:2];
    logic [31:0] mem_rdata [0:2];

    logic        ack_w   [0:2];
    logic        err_w   [0:2];
    logic        req_w   [0:2];
    logic        we_w    [0:2];
    logic        busy_w  [0:2];
    logic [31:0] rdata_w [0:2];
    logic [31:0] wdata_w [0:2];
    logic [31:0] strb_w  [0:2];
    logic [19:0] addr_w  [0:2];

    int lat_p [0:2] = '{1, 2, 3};
    int tmo_p [0:2] = '{0, 6, 0};

    // Expected per-cycle schedule, filled in when a transaction is issued.
    bit        exp_req   [0:2][0:MAXC-1];
    bit        exp_ack   [0:2][0:MAXC-1];
    bit        exp_err   [0:2][0:MAXC-1];
    bit        exp_busy  [0:2][0:MAXC-1];
    bit        exp_we    [0:2][0:MAXC-1];
    bit [31:0] exp_rdata [0:2][0:MAXC-1];
    bit [31:0] exp_wdata [0:2][0:MAXC-1];
    bit [31:0] exp_strb  [0:2][0:MAXC-1];
    bit [19:0] exp_addr  [0:2][0:MAXC-1];
    bit [31:0] last_rdata [0:2];

    // Observations recorded by the compare process for literal checks.
    int        obs_ack_cyc   [0:2];
    int        obs_req_cnt   [0:2];
    logic [31:0] obs_ack_rdata [0:2];
    logic      obs_ack_err   [0:2];
    logic [19:0] obs_addr    [0:2];
    logic [31:0] obs_strb    [0:2];
    logic      obs_we        [0:2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    kronos_mem_adapter #(.AddrW(20), .DataW(32), .MemLatency(1), .TimeoutCycles(0)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req[0]), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_mask_i(core_mask), .core_we_i(core_we),
        .core_ack_o(ack_w[0]), .core_rdata_o(rdata_w[0]), .core_err_o(err_w[0]),
        .mem_req_o(req_w[0]), .mem_gnt_i(mem_gnt[0]), .mem_addr_o(addr_w[0]),
        .mem_wdata_o(wdata_w[0]), .mem_strb_o(strb_w[0]), .mem_we_o(we_w[0]),
        .mem_rdata_i(mem_rdata[0]), .busy_o(busy_w[0])
    );

    kronos_mem_adapter #(.AddrW(20), .DataW(32), .MemLatency(2), .TimeoutCycles(6)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req[1]), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_mask_i(core_mask), .core_we_i(core_we),
        .core_ack_o(ack_w[1]), .core_rdata_o(rdata_w[1]), .core_err_o(err_w[1]),
        .mem_req_o(req_w[1]), .mem_gnt_i(mem_gnt[1]), .mem_addr_o(addr_w[1]),
        .mem_wdata_o(wdata_w[1]), .mem_strb_o(strb_w[1]), .mem_we_o(we_w[1]),
        .mem_rdata_i(mem_rdata[1]), .busy_o(busy_w[1])
    );

    kronos_mem_adapter #(.AddrW(20), .DataW(32), .MemLatency(3), .TimeoutCycles(0)) u_dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req[2]), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_mask_i(core_mask), .core_we_i(core_we),
        .core_ack_o(ack_w[2]), .core_rdata_o(rdata_w[2]), .core_err_o(err_w[2]),
        .mem_req_o(req_w[2]), .mem_gnt_i(mem_gnt[2]), .mem_addr_o(addr_w[2]),
        .mem_wdata_o(wdata_w[2]), .mem_strb_o(strb_w[2]), .mem_we_o(we_w[2]),
        .mem_rdata_i(mem_rdata[2]), .busy_o(busy_w[2])
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic bit [31:0] strb_of(input bit [3:0] m);
        bit [31:0] s;
        for (int i = 0; i < 32; i++) s[i] = m[i / 8];
        return s;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Per-cycle comparison of every adapter against the expected schedule.
    always @(negedge clk_i) begin
        if (cyc < MAXC) begin
            for (int d = 0; d < 3; d++) begin
                chk("mem_req", d, 32'(req_w[d]), 32'(exp_req[d][cyc]));
                chk("core_ack", d, 32'(ack_w[d]), 32'(exp_ack[d][cyc]));
                chk("core_err", d, 32'(err_w[d]), 32'(exp_err[d][cyc]));
                chk("busy", d, 32'(busy_w[d]), 32'(exp_busy[d][cyc]));
                if (exp_ack[d][cyc]) chk("core_rdata", d, rdata_w[d], exp_rdata[d][cyc]);
                if (exp_req[d][cyc]) begin
                    chk("mem_addr", d, 32'(addr_w[d]), 32'(exp_addr[d][cyc]));
                    chk("mem_wdata", d, wdata_w[d], exp_wdata[d][cyc]);
                    chk("mem_strb", d, strb_w[d], exp_strb[d][cyc]);
                    chk("mem_we", d, 32'(we_w[d]), 32'(exp_we[d][cyc]));
                end
                if (ack_w[d] === 1'b1) begin
                    obs_ack_cyc[d]   = cyc;
                    obs_ack_rdata[d] = rdata_w[d];
                    obs_ack_err[d]   = err_w[d];
                end
                if (req_w[d] === 1'b1) begin
                    obs_req_cnt[d] = obs_req_cnt[d] + 1;
                    obs_addr[d]    = addr_w[d];
                    obs_strb[d]    = strb_w[d];
                    obs_we[d]      = we_w[d];
                end
            end
        end
    end

    // Issue one transaction on adapter d. stall = grant delay in cycles after
    // entering REQ (negative = never). Returns at the IDLE cycle after the ack.
    task automatic run_txn(input int d, input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                           input bit [3:0] mask, input int stall, input bit [31:0] rval,
                           output int c0);
        int  lat, tmo, g, last_req, a;
        bit  timed_out;
        lat = lat_p[d];
        tmo = tmo_p[d];
        c0  = cyc;
        timed_out = (tmo != 0) && ((stall < 0) || (stall >= tmo));
        g        = c0 + 1 + stall;
        last_req = timed_out ? c0 + tmo : g;
        a        = timed_out ? c0 + tmo + 1 : g + lat + 1;
        if (timed_out) last_rdata[d] = 32'h0;
        else if (!we)  last_rdata[d] = rval;
        for (int t = c0 + 1; t <= a; t++) exp_busy[d][t] = 1'b1;
        for (int t = c0 + 1; t <= last_req; t++) begin
            exp_req[d][t]   = 1'b1;
            exp_addr[d][t]  = addr[19:0];
            exp_wdata[d][t] = wdata;
            exp_strb[d][t]  = strb_of(mask);
            exp_we[d][t]    = we;
        end
        exp_ack[d][a]   = 1'b1;
        exp_err[d][a]   = timed_out;
        exp_rdata[d][a] = last_rdata[d];
        obs_req_cnt[d]  = 0;
        obs_ack_cyc[d]  = -1;

        core_addr   = addr;
        core_wdata  = wdata;
        core_mask   = mask;
        core_we     = we;
        core_req[d] = 1'b1;
        for (int t = c0 + 1; t <= a + 1; t++) begin
            step();
            mem_gnt[d]   = !timed_out && (t == g);
            mem_rdata[d] = (t == g + lat) ? rval : 32'hDEAD_BEEF;
            if (t == c0 + 2) begin
                // Mid-transaction input changes must not reach the memory side.
                core_addr  = ~addr;
                core_wdata = ~wdata;
                core_mask  = ~mask;
                core_we    = ~we;
            end
            if (t == a + 1) core_req[d] = 1'b0;
        end
    endtask

    initial begin
        int c0, c1;
        rst_ni     = 1'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        core_mask  = 4'h0;
        core_we    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            core_req[d]   = 1'b0;
            mem_gnt[d]    = 1'b0;
            mem_rdata[d]  = 32'h0;
            last_rdata[d] = 32'h0;
            obs_ack_cyc[d] = -1;
            obs_req_cnt[d] = 0;
        end
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_addr", d, 32'(addr_w[d]), 32'h0);
            chk("rst_wdata", d, wdata_w[d], 32'h0);
            chk("rst_strb", d, strb_w[d], 32'h0);
            chk("rst_we", d, 32'(we_w[d]), 32'h0);
            chk("rst_rdata", d, rdata_w[d], 32'h0);
        end
        rst_ni = 1'b1;
        step();

        // A: read, latency 1, immediate grant.
        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, c0);
        chk("lit_rd_addr", 0, 32'(obs_addr[0]), 32'h0000_0010);
        chk("lit_rd_ackcyc", 0, obs_ack_cyc[0], c0 + 3);
        chk("lit_rd_rdata", 0, obs_ack_rdata[0], 32'h1234_5678);
        chk("lit_rd_err", 0, 32'(obs_ack_err[0]), 32'h0);
        // A: back-to-back, issued in the IDLE cycle after RESP.
        run_txn(0, 1'b0, 32'h0004_2000, 32'h0, 4'hF, 0, 32'h0F0F_1E1E, c1);
        chk("lit_b2b_interval", 0, c1 - c0, 4);
        chk("lit_b2b_rdata", 0, obs_ack_rdata[0], 32'h0F0F_1E1E);

        // C: read then write; the write must leave read data untouched.
        run_txn(2, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'hCAFE_F00D, c0);
        run_txn(2, 1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, c0);
        chk("lit_wr_strb", 2, obs_strb[2], 32'h00FF_00FF);
        chk("lit_wr_we", 2, 32'(obs_we[2]), 32'h1);
        chk("lit_wr_ackcyc", 2, obs_ack_cyc[2], c0 + 5);
        chk("lit_wr_rdata", 2, obs_ack_rdata[2], 32'hCAFE_F00D);

        // B: grant stalled 4 cycles, latency 2.
        run_txn(1, 1'b0, 32'h0001_2340, 32'h0, 4'hF, 4, 32'h7777_8888, c0);
        chk("lit_stall_reqcnt", 1, obs_req_cnt[1], 5);
        chk("lit_stall_ackcyc", 1, obs_ack_cyc[1], c0 + 8);
        chk("lit_stall_rdata", 1, obs_ack_rdata[1], 32'h7777_8888);
        // B: no grant at all -> timeout error.
        run_txn(1, 1'b0, 32'h0001_0000, 32'h0, 4'hF, -1, 32'h0, c0);
        chk("lit_to_reqcnt", 1, obs_req_cnt[1], 6);
        chk("lit_to_ackcyc", 1, obs_ack_cyc[1], c0 + 7);
        chk("lit_to_err", 1, 32'(obs_ack_err[1]), 32'h1);
        chk("lit_to_rdata", 1, obs_ack_rdata[1], 32'h0);
        // B: next request completes normally.
        run_txn(1, 1'b0, 32'h0001_0004, 32'h0, 4'hF, 1, 32'h1357_9BDF, c0);
        chk("lit_after_to_err", 1, 32'(obs_ack_err[1]), 32'h0);
        chk("lit_after_to_rdata", 1, obs_ack_rdata[1], 32'h1357_9BDF);
        // B: grant lands in the timeout cycle itself -> no error.
        run_txn(1, 1'b0, 32'h0001_0008, 32'h0, 4'hF, 5, 32'h2468_ACE0, c0);
        chk("lit_edge_err", 1, 32'(obs_ack_err[1]), 32'h0);
        chk("lit_edge_ackcyc", 1, obs_ack_cyc[1], c0 + 9);
        chk("lit_edge_rdata", 1, obs_ack_rdata[1], 32'h2468_ACE0);

        // C: reset pulsed while waiting on read data.
        c0 = cyc;
        obs_ack_cyc[2] = -1;
        for (int t = c0 + 1; t <= c0 + 2; t++) exp_busy[2][t] = 1'b1;
        exp_req[2][c0 + 1]   = 1'b1;
        exp_addr[2][c0 + 1]  = 20'h00400;
        exp_wdata[2][c0 + 1] = 32'h0;
        exp_strb[2][c0 + 1]  = 32'hFFFF_FFFF;
        exp_we[2][c0 + 1]    = 1'b0;
        core_addr = 32'h0000_0400; core_wdata = 32'h0; core_mask = 4'hF; core_we = 1'b0;
        core_req[2] = 1'b1;
        step();
        mem_gnt[2] = 1'b1;
        step();
        mem_gnt[2] = 1'b0;
        step();
        rst_ni = 1'b0;
        core_req[2] = 1'b0;
        for (int d = 0; d < 3; d++) last_rdata[d] = 32'h0;
        #1;
        chk("rstmid_ack", 2, 32'(ack_w[2]), 32'h0);
        chk("rstmid_req", 2, 32'(req_w[2]), 32'h0);
        chk("rstmid_busy", 2, 32'(busy_w[2]), 32'h0);
        chk("rstmid_addr", 2, 32'(addr_w[2]), 32'h0);
        chk("rstmid_strb", 2, strb_w[2], 32'h0);
        chk("rstmid_rdata", 2, rdata_w[2], 32'h0);
        step();
        rst_ni = 1'b1;
        mem_rdata[2] = 32'h5555_AAAA;
        step();
        mem_rdata[2] = 32'hDEAD_BEEF;
        repeat (4) step();
        chk("rstmid_no_ack", 2, obs_ack_cyc[2], -1);
        run_txn(2, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 0, 32'h0BAD_C0DE, c0);
        chk("lit_postrst_ackcyc", 2, obs_ack_cyc[2], c0 + 5);
        chk("lit_postrst_rdata", 2, obs_ack_rdata[2], 32'h0BAD_C0DE);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
